// File: rtl/count_check_pkg.sv
// Shared types and constants for the count sequence checker.
package count_check_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_TRACK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  localparam int ERR_CNT_W = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = '1;

endpackage

// File: rtl/count_sequence_checker_period_meter.sv
// Saturating count of cycles since the last change, plus the one-shot stall flag.
module period_meter
  import count_check_pkg::*;
#(
  parameter int DIV = 50_000_000,
  parameter int TOL = 0,
  parameter int PW  = $clog2(2*DIV+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          change_i,
  output logic [PW-1:0] cyc_o,
  output logic          stall_o
);

  localparam logic [PW-1:0] CYC_SAT   = PW'(2*DIV);
  localparam logic [PW-1:0] CYC_STALL = PW'(DIV+TOL+1);

  logic [PW-1:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (change_i) begin
      cyc_d = PW'(1);
    end else if (cyc_q != CYC_SAT) begin
      cyc_d = cyc_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  // A change at the threshold is judged as a (late) change, never as a stall.
  assign stall_o = (cyc_q == CYC_STALL) && !change_i;
  assign cyc_o   = cyc_q;

endmodule

// File: rtl/count_sequence_checker.sv
// Receive-side monitor: checks each COUNT_IN change for +1 sequence and DIV+-TOL spacing.
//   state     | meaning
//   ST_SEARCH | no reference yet; first change only establishes one
//   ST_TRACK  | checking changes, counting good steps toward lock
//   ST_LOCKED | LOCK_N consecutive good steps seen; LOCKED asserted
module count_sequence_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int DIV    = 50_000_000,
  parameter int TOL    = 0,
  parameter int LOCK_N = 3,
  parameter int PW     = $clog2(2*DIV+1)
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic [WIDTH-1:0]     COUNT_IN,
  output logic                 LOCKED,
  output logic                 STEP,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [PW-1:0]        PERIOD
);

  localparam int GC_W = $clog2(LOCK_N+1);
  localparam logic [PW-1:0]   CYC_LO  = PW'(DIV-TOL);
  localparam logic [PW-1:0]   CYC_HI  = PW'(DIV+TOL);
  localparam logic [GC_W-1:0] GC_LAST = GC_W'(LOCK_N-1);

  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [PW-1:0]        cyc;
  logic                 stall;
  logic                 change;
  logic                 good;

  state_e               state_q, state_d;
  logic [GC_W-1:0]      good_cnt_q, good_cnt_d;
  logic                 locked_q, locked_d;
  logic                 step_q, step_d;
  logic                 err_q, err_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [PW-1:0]        period_q, period_d;

  period_meter #(
    .DIV (DIV),
    .TOL (TOL),
    .PW  (PW)
  ) u_period_meter (
    .clk      (CLK),
    .rst_n    (RSTn),
    .change_i (change),
    .cyc_o    (cyc),
    .stall_o  (stall)
  );

  assign change = (COUNT_IN != prev_q);
  assign good   = (COUNT_IN == prev_q + WIDTH'(1)) && (cyc >= CYC_LO) && (cyc <= CYC_HI);

  always_comb begin
    prev_d     = COUNT_IN;
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    locked_d   = locked_q;
    step_d     = 1'b0;
    err_d      = 1'b0;
    period_d   = period_q;
    err_cnt_d  = err_cnt_q;

    unique case (state_q)
      ST_SEARCH: begin
        if (change) begin
          state_d    = ST_TRACK;
          good_cnt_d = '0;
        end
      end
      ST_TRACK: begin
        if (change) begin
          period_d = cyc;
          if (good) begin
            step_d = 1'b1;
            if (good_cnt_q == GC_LAST) begin
              state_d    = ST_LOCKED;
              locked_d   = 1'b1;
              good_cnt_d = '0;
            end else begin
              good_cnt_d = good_cnt_q + GC_W'(1);
            end
          end else begin
            err_d      = 1'b1;
            good_cnt_d = '0;
          end
        end else if (stall) begin
          err_d      = 1'b1;
          state_d    = ST_SEARCH;
          good_cnt_d = '0;
        end
      end
      ST_LOCKED: begin
        if (change) begin
          period_d = cyc;
          if (good) begin
            step_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            locked_d   = 1'b0;
            state_d    = ST_TRACK;
            good_cnt_d = '0;
          end
        end else if (stall) begin
          err_d      = 1'b1;
          locked_d   = 1'b0;
          state_d    = ST_SEARCH;
          good_cnt_d = '0;
        end
      end
      default: begin
        state_d    = ST_SEARCH;
        locked_d   = 1'b0;
        good_cnt_d = '0;
      end
    endcase

    if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // prev keeps loading through reset so release never looks like a change.
  always_ff @(posedge CLK) begin
    prev_q <= prev_d;
    if (!RSTn) begin
      state_q    <= ST_SEARCH;
      good_cnt_q <= '0;
      locked_q   <= 1'b0;
      step_q     <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      period_q   <= '0;
    end else begin
      state_q    <= state_d;
      good_cnt_q <= good_cnt_d;
      locked_q   <= locked_d;
      step_q     <= step_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      period_q   <= period_d;
    end
  end

  assign LOCKED  = locked_q;
  assign STEP    = step_q;
  assign ERR     = err_q;
  assign ERR_CNT = err_cnt_q;
  assign PERIOD  = period_q;

endmodule
